// File: rtl/dc_frame_packer_if.sv
// Request/status and FIFO-write signals between a frame requester and dc_frame_packer.
// The requester side is "master"; the packer side is "slave".
interface dc_frame_packer_if #(
  parameter int FRAME_WORDS = 62
);
  logic [FRAME_WORDS-1:0][31:0] i_dc_regs;
  logic [4:0]                   i_channel_sel;
  logic                         i_frame_req;
  logic [3:0][31:0]             i_launch_cmd;
  logic                         i_launch_req;
  logic                         o_ready;
  logic                         i_fifo_full;
  logic                         o_fifo_wr;
  logic [31:0]                  o_fifo_data;
  logic                         o_frame_done;
  logic                         o_launch_done;
  logic                         o_err;

  modport master (
    output i_dc_regs, i_channel_sel, i_frame_req, i_launch_cmd, i_launch_req, i_fifo_full,
    input  o_ready, o_fifo_wr, o_fifo_data, o_frame_done, o_launch_done, o_err
  );

  modport slave (
    input  i_dc_regs, i_channel_sel, i_frame_req, i_launch_cmd, i_launch_req, i_fifo_full,
    output o_ready, o_fifo_wr, o_fifo_data, o_frame_done, o_launch_done, o_err
  );
endinterface

// File: rtl/dc_frame_packer.sv
// Serialises either a DC frame (header + data words) or a 5-word launch command into a
// downstream FIFO, honouring FIFO back-pressure word by word.
module dc_frame_packer #(
  parameter int DAC_CHANNEL = 24,
  parameter int FRAME_WORDS = 62
) (
  input  logic           i_clk,
  input  logic           i_rst,
  dc_frame_packer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    SEND_FRAME,
    SEND_LAUNCH
  } state_t;

  state_t                       state_q, state_d;
  logic [5:0]                   cnt_q, cnt_d;
  logic [FRAME_WORDS-1:0][31:0] dc_q, dc_d;
  logic [4:0]                   chSel_q, chSel_d;
  logic [3:0][31:0]             cmd_q, cmd_d;
  logic                         frameDone_q, frameDone_d;
  logic                         launchDone_q, launchDone_d;
  logic                         err_q, err_d;
  logic [31:0]                  header;
  logic [31:0]                  curWord;
  logic                         chValid;
  logic                         wr;

  assign chValid = (32'(bus.i_channel_sel) < 32'(DAC_CHANNEL));
  assign wr      = (state_q != IDLE) && !bus.i_fifo_full;

  // Channel-select field is active-low one-hot: every DAC bit set except the target.
  always_comb begin
    header = dc_q[0];
    for (int i = 0; i < DAC_CHANNEL; i++) begin
      header[8+i] = (5'(i) != chSel_q);
    end
  end

  always_comb begin
    curWord = 32'd0;
    case (state_q)
      SEND_FRAME:  curWord = (cnt_q == 6'd0) ? header : dc_q[cnt_q];
      SEND_LAUNCH: curWord = (cnt_q == 6'd0) ? 32'hFFFF_FFFF : cmd_q[2'(cnt_q - 6'd1)];
      default:     curWord = 32'd0;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    dc_d         = dc_q;
    chSel_d      = chSel_q;
    cmd_d        = cmd_q;
    frameDone_d  = 1'b0;
    launchDone_d = 1'b0;
    err_d        = 1'b0;
    case (state_q)
      IDLE: begin
        // Launch wins over a simultaneous frame request; the frame request is dropped.
        if (bus.i_launch_req) begin
          cmd_d   = bus.i_launch_cmd;
          cnt_d   = 6'd0;
          state_d = SEND_LAUNCH;
        end else if (bus.i_frame_req) begin
          if (chValid) begin
            dc_d    = bus.i_dc_regs;
            chSel_d = bus.i_channel_sel;
            cnt_d   = 6'd0;
            state_d = SEND_FRAME;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      SEND_FRAME: begin
        if (wr) begin
          if (cnt_q == 6'(FRAME_WORDS - 1)) begin
            state_d     = IDLE;
            cnt_d       = 6'd0;
            frameDone_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 6'd1;
          end
        end
      end
      SEND_LAUNCH: begin
        if (wr) begin
          if (cnt_q == 6'd4) begin
            state_d      = IDLE;
            cnt_d        = 6'd0;
            launchDone_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 6'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q      <= IDLE;
      cnt_q        <= 6'd0;
      dc_q         <= '0;
      chSel_q      <= 5'd0;
      cmd_q        <= '0;
      frameDone_q  <= 1'b0;
      launchDone_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      dc_q         <= dc_d;
      chSel_q      <= chSel_d;
      cmd_q        <= cmd_d;
      frameDone_q  <= frameDone_d;
      launchDone_q <= launchDone_d;
      err_q        <= err_d;
    end
  end

  assign bus.o_ready       = (state_q == IDLE);
  assign bus.o_fifo_wr     = wr;
  assign bus.o_fifo_data   = curWord;
  assign bus.o_frame_done  = frameDone_q;
  assign bus.o_launch_done = launchDone_q;
  assign bus.o_err         = err_q;

endmodule

// File: tb/tb_dc_frame_packer.sv
// Directed bench for dc_frame_packer: each task drives one scenario and checks the FIFO
// write stream against hand-computed words, sampling half a cycle away from the clock edge.
module tb_dc_frame_packer;

  logic clk;
  logic rstN;
  int   total;
  int   bad;

  dc_frame_packer_if #(.FRAME_WORDS(62)) bus ();

  dc_frame_packer #(
    .DAC_CHANNEL(24),
    .FRAME_WORDS(62)
  ) dut (
    .i_clk (clk),
    .i_rst (rstN),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus();
    for (int k = 0; k < 62; k++) bus.i_dc_regs[k] = 32'd0;
    bus.i_channel_sel = 5'd0;
    bus.i_frame_req   = 1'b0;
    for (int k = 0; k < 4; k++) bus.i_launch_cmd[k] = 32'd0;
    bus.i_launch_req  = 1'b0;
    bus.i_fifo_full   = 1'b0;
  endtask

  task automatic test_reset();
    rstN = 1'b0;
    applyStimulus();
    @(negedge clk);
    @(negedge clk);
    total++; if (bus.o_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_ready: got %b want 1", bus.o_ready); end
    total++; if (bus.o_fifo_wr !== 1'b0) begin bad++; $display("[TB] FAIL reset_wr: got %b want 0", bus.o_fifo_wr); end
    total++; if (bus.o_fifo_data !== 32'd0) begin bad++; $display("[TB] FAIL reset_data: got %h want 0", bus.o_fifo_data); end
    total++; if ({bus.o_frame_done, bus.o_launch_done, bus.o_err} !== 3'b000) begin bad++; $display("[TB] FAIL reset_pulses: got %b want 000", {bus.o_frame_done, bus.o_launch_done, bus.o_err}); end
    rstN = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_frame();
    logic [31:0] want;
    for (int k = 0; k < 62; k++) bus.i_dc_regs[k] = 32'(k);
    bus.i_channel_sel = 5'd5;
    bus.i_frame_req   = 1'b1;
    @(negedge clk);
    bus.i_frame_req = 1'b0;
    for (int k = 0; k < 62; k++) bus.i_dc_regs[k] = 32'hDEAD_0000;
    for (int k = 0; k < 62; k++) begin
      want = (k == 0) ? 32'hFFFF_DF00 : 32'(k);
      bus.i_launch_req = (k == 5);
      #1;
      total++;
      if (bus.o_fifo_wr !== 1'b1 || bus.o_fifo_data !== want || bus.o_frame_done !== 1'b0 || bus.o_ready !== 1'b0) begin
        bad++;
        $display("[TB] FAIL frame_word%0d: wr=%b data=%h done=%b ready=%b want wr=1 data=%h done=0 ready=0",
                 k, bus.o_fifo_wr, bus.o_fifo_data, bus.o_frame_done, bus.o_ready, want);
      end
      @(negedge clk);
    end
    bus.i_launch_req = 1'b0;
    total++; if (bus.o_frame_done !== 1'b1 || bus.o_ready !== 1'b1 || bus.o_fifo_wr !== 1'b0) begin bad++; $display("[TB] FAIL frame_done: done=%b ready=%b wr=%b want 1 1 0", bus.o_frame_done, bus.o_ready, bus.o_fifo_wr); end
    @(negedge clk);
    total++; if (bus.o_frame_done !== 1'b0 || bus.o_fifo_wr !== 1'b0 || bus.o_launch_done !== 1'b0) begin bad++; $display("[TB] FAIL frame_done_once: done=%b wr=%b ldone=%b want 0 0 0", bus.o_frame_done, bus.o_fifo_wr, bus.o_launch_done); end
  endtask

  task automatic test_launch();
    logic [31:0] want [5];
    want = '{32'hFFFF_FFFF, 32'h1111_AAAA, 32'h2222_BBBB, 32'h3333_CCCC, 32'h4444_DDDD};
    bus.i_launch_cmd[0] = 32'h1111_AAAA;
    bus.i_launch_cmd[1] = 32'h2222_BBBB;
    bus.i_launch_cmd[2] = 32'h3333_CCCC;
    bus.i_launch_cmd[3] = 32'h4444_DDDD;
    bus.i_launch_req    = 1'b1;
    @(negedge clk);
    bus.i_launch_req = 1'b0;
    for (int k = 0; k < 4; k++) bus.i_launch_cmd[k] = 32'h0BAD_0BAD;
    for (int k = 0; k < 5; k++) begin
      #1;
      total++;
      if (bus.o_fifo_wr !== 1'b1 || bus.o_fifo_data !== want[k]) begin
        bad++;
        $display("[TB] FAIL launch_word%0d: wr=%b data=%h want wr=1 data=%h", k, bus.o_fifo_wr, bus.o_fifo_data, want[k]);
      end
      @(negedge clk);
    end
    total++; if (bus.o_launch_done !== 1'b1 || bus.o_fifo_wr !== 1'b0) begin bad++; $display("[TB] FAIL launch_done: ldone=%b wr=%b want 1 0", bus.o_launch_done, bus.o_fifo_wr); end
    @(negedge clk);
    total++; if (bus.o_launch_done !== 1'b0) begin bad++; $display("[TB] FAIL launch_done_once: got %b want 0", bus.o_launch_done); end
  endtask

  task automatic test_simultaneous();
    logic [31:0] want [5];
    want = '{32'hFFFF_FFFF, 32'hA0A0_0001, 32'hA0A0_0002, 32'hA0A0_0003, 32'hA0A0_0004};
    for (int k = 0; k < 62; k++) bus.i_dc_regs[k] = 32'h5555_0000;
    for (int k = 0; k < 4; k++) bus.i_launch_cmd[k] = 32'hA0A0_0001 + 32'(k);
    bus.i_channel_sel = 5'd3;
    bus.i_frame_req   = 1'b1;
    bus.i_launch_req  = 1'b1;
    @(negedge clk);
    bus.i_frame_req  = 1'b0;
    bus.i_launch_req = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      total++;
      if (bus.o_fifo_wr !== 1'b1 || bus.o_fifo_data !== want[k]) begin
        bad++;
        $display("[TB] FAIL simul_word%0d: wr=%b data=%h want wr=1 data=%h", k, bus.o_fifo_wr, bus.o_fifo_data, want[k]);
      end
      @(negedge clk);
    end
    total++; if (bus.o_launch_done !== 1'b1 || bus.o_frame_done !== 1'b0) begin bad++; $display("[TB] FAIL simul_done: ldone=%b fdone=%b want 1 0", bus.o_launch_done, bus.o_frame_done); end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      total++; if (bus.o_fifo_wr !== 1'b0 || bus.o_ready !== 1'b1) begin bad++; $display("[TB] FAIL simul_no_frame%0d: wr=%b ready=%b want 0 1", c, bus.o_fifo_wr, bus.o_ready); end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] want;
    int idx;
    int stalls;
    bus.i_dc_regs[0] = 32'h0000_00A5;
    for (int k = 1; k < 62; k++) bus.i_dc_regs[k] = 32'(k + 100);
    bus.i_channel_sel = 5'd23;
    bus.i_frame_req   = 1'b1;
    @(negedge clk);
    bus.i_frame_req = 1'b0;
    idx    = 0;
    stalls = 0;
    for (int c = 0; c < 200 && idx < 62; c++) begin
      if (idx == 11 && stalls < 3) begin
        bus.i_fifo_full = 1'b1;
        #1;
        total++;
        if (bus.o_fifo_wr !== 1'b0 || bus.o_fifo_data !== 32'd111) begin
          bad++;
          $display("[TB] FAIL bp_stall%0d: wr=%b data=%h want wr=0 data=%h", stalls, bus.o_fifo_wr, bus.o_fifo_data, 32'd111);
        end
        stalls++;
      end else begin
        bus.i_fifo_full = 1'b0;
        want = (idx == 0) ? 32'h7FFF_FFA5 : 32'(idx + 100);
        #1;
        total++;
        if (bus.o_fifo_wr !== 1'b1 || bus.o_fifo_data !== want) begin
          bad++;
          $display("[TB] FAIL bp_word%0d: wr=%b data=%h want wr=1 data=%h", idx, bus.o_fifo_wr, bus.o_fifo_data, want);
        end
        idx++;
      end
      @(negedge clk);
    end
    bus.i_fifo_full = 1'b0;
    total++; if (idx !== 62) begin bad++; $display("[TB] FAIL bp_count: got %0d want 62", idx); end
    total++; if (bus.o_frame_done !== 1'b1 || bus.o_fifo_wr !== 1'b0) begin bad++; $display("[TB] FAIL bp_done: done=%b wr=%b want 1 0", bus.o_frame_done, bus.o_fifo_wr); end
    @(negedge clk);
  endtask

  task automatic test_bad_channel();
    bus.i_channel_sel = 5'd24;
    bus.i_frame_req   = 1'b1;
    @(negedge clk);
    bus.i_frame_req = 1'b0;
    total++; if (bus.o_err !== 1'b1 || bus.o_fifo_wr !== 1'b0 || bus.o_ready !== 1'b1) begin bad++; $display("[TB] FAIL badch_err: err=%b wr=%b ready=%b want 1 0 1", bus.o_err, bus.o_fifo_wr, bus.o_ready); end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      total++; if (bus.o_err !== 1'b0 || bus.o_fifo_wr !== 1'b0 || bus.o_ready !== 1'b1) begin bad++; $display("[TB] FAIL badch_idle%0d: err=%b wr=%b ready=%b want 0 0 1", c, bus.o_err, bus.o_fifo_wr, bus.o_ready); end
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [31:0] want;
    for (int k = 0; k < 62; k++) bus.i_dc_regs[k] = 32'(k);
    bus.i_channel_sel = 5'd5;
    bus.i_frame_req   = 1'b1;
    @(negedge clk);
    bus.i_frame_req = 1'b0;
    for (int k = 0; k < 21; k++) begin
      want = (k == 0) ? 32'hFFFF_DF00 : 32'(k);
      total++;
      if (bus.o_fifo_wr !== 1'b1 || bus.o_fifo_data !== want) begin
        bad++;
        $display("[TB] FAIL rst_pre_word%0d: wr=%b data=%h want wr=1 data=%h", k, bus.o_fifo_wr, bus.o_fifo_data, want);
      end
      @(negedge clk);
    end
    rstN = 1'b0;
    for (int k = 0; k < 62; k++) bus.i_dc_regs[k] = 32'(k * 3);
    bus.i_channel_sel = 5'd7;
    bus.i_frame_req   = 1'b1;
    #1;
    total++;
    if (bus.o_ready !== 1'b1 || bus.o_fifo_wr !== 1'b0 || bus.o_fifo_data !== 32'd0 || {bus.o_frame_done, bus.o_launch_done, bus.o_err} !== 3'b000) begin
      bad++;
      $display("[TB] FAIL rst_mid_outputs: ready=%b wr=%b data=%h pulses=%b want 1 0 0 000",
               bus.o_ready, bus.o_fifo_wr, bus.o_fifo_data, {bus.o_frame_done, bus.o_launch_done, bus.o_err});
    end
    @(negedge clk);
    rstN = 1'b1;
    @(negedge clk);
    bus.i_frame_req = 1'b0;
    total++; if (bus.o_fifo_wr !== 1'b1 || bus.o_fifo_data !== 32'hFFFF_7F00) begin bad++; $display("[TB] FAIL rst_new_header: wr=%b data=%h want wr=1 data=ffff7f00", bus.o_fifo_wr, bus.o_fifo_data); end
    @(negedge clk);
    total++; if (bus.o_fifo_wr !== 1'b1 || bus.o_fifo_data !== 32'd3) begin bad++; $display("[TB] FAIL rst_new_word1: wr=%b data=%h want wr=1 data=00000003", bus.o_fifo_wr, bus.o_fifo_data); end
    rstN = 1'b0;
    @(negedge clk);
    rstN = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    bus.i_launch_cmd[0] = 32'hC0DE_0000;
    bus.i_launch_cmd[1] = 32'hC0DE_0001;
    bus.i_launch_cmd[2] = 32'hC0DE_0002;
    bus.i_launch_cmd[3] = 32'hC0DE_0003;
    bus.i_launch_req    = 1'b1;
    @(negedge clk);
    bus.i_launch_req = 1'b0;
    for (int k = 0; k < 5; k++) @(negedge clk);
    total++; if (bus.o_launch_done !== 1'b1 || bus.o_ready !== 1'b1) begin bad++; $display("[TB] FAIL b2b_done_ready: ldone=%b ready=%b want 1 1", bus.o_launch_done, bus.o_ready); end
    for (int k = 0; k < 62; k++) bus.i_dc_regs[k] = 32'(k + 7);
    bus.i_dc_regs[0]  = 32'd0;
    bus.i_channel_sel = 5'd0;
    bus.i_frame_req   = 1'b1;
    @(negedge clk);
    bus.i_frame_req = 1'b0;
    total++; if (bus.o_fifo_wr !== 1'b1 || bus.o_fifo_data !== 32'hFFFF_FE00) begin bad++; $display("[TB] FAIL b2b_header: wr=%b data=%h want wr=1 data=fffffe00", bus.o_fifo_wr, bus.o_fifo_data); end
    @(negedge clk);
    total++; if (bus.o_fifo_wr !== 1'b1 || bus.o_fifo_data !== 32'd8) begin bad++; $display("[TB] FAIL b2b_word1: wr=%b data=%h want wr=1 data=00000008", bus.o_fifo_wr, bus.o_fifo_data); end
    rstN = 1'b0;
    @(negedge clk);
    rstN = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_frame();
    test_launch();
    test_simultaneous();
    test_backpressure();
    test_bad_channel();
    test_reset_mid_frame();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
